dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port data memory (`memory_reg_file`) between the RV32I core's load/store port and a debug/loader port. Each transfer is sequenced as request, memory access, latency wait, then a one-cycle acknowledge. While the core's access is pending, the block asserts a stall to the core. It sits between the core datapath (ALU_Out/rd2/MemWr/MemRead) and the data memory instance.

## Interface
Parameters:
- MEM_LAT, 1, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..7
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock; all logic on rising edge
- n_rst  in  1  reset, synchronous and active-low
- core_req  in  1  core access request; held until `core_ack`
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  byte address
- core_wdata  in  32  store data
- core_rdata  out  32  load data; valid when `core_ack`=1
- core_ack  out  1  one-cycle completion pulse
- core_stall  out  1  `core_req & ~core_ack`; combinational
- dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/ADDR_W/32  debug port; same rules as the core port
- dbg_rdata  out  32  debug load data
- dbg_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory strobe; high exactly one cycle per transfer
- mem_we  out  1  write enable; only ever high together with `mem_en`
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  32  latched write data
- mem_rdata  in  32  memory read data
- grant_dbg  out  1  1 while the debug port owns the transfer in flight

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any request is present, pick the owner (see Configuration).
  - Latch the owner's we/addr/wdata into `mem_*`, then go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS:
  - `mem_en`=1; `mem_we`=latched we.
  - Load the wait counter with MEM_LAT-1, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `mem_rdata` into the owner's rdata register, then go to RESP.
  - On stores, rdata is captured anyway and its value is don't-care.
- RESP:
  - Owner's ack=1 for one cycle, then go to IDLE.
  - The non-owner's ack stays 0.
- Request/data inputs are sampled only in IDLE. Changes during ACCESS/WAIT/RESP are ignored.
- Requesters must hold req/we/addr/wdata stable until ack. They may drop or change req in the ack cycle, and IDLE samples the new value.
- A req still high after ack is a new transfer.
- The counter is 3 bits. No wrap is possible in the legal range.

## Timing
- Request seen in IDLE at cycle 0 → `mem_en` in cycle 1 → `mem_rdata` valid in cycle 1+MEM_LAT → ack in cycle MEM_LAT+2.
- Throughput: one transfer per MEM_LAT+3 cycles, including the IDLE cycle.
- `core_stall` is high from cycle 0 through cycle MEM_LAT+1 and low in the ack cycle.
- Simultaneous requests: one winner per IDLE cycle. The loser's request is held and served in the next IDLE.
- Reset (`n_rst`=0 at an edge), including mid-transfer:
  - State goes to IDLE; the transfer is aborted and no ack is issued.
  - All outputs go to 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both rdata registers, both acks, `grant_dbg`.
  - The arbitration history bit is set to "debug last served".
- `core_stall` is combinational from `core_req`, so it may be high during reset.

## Configuration
- ARB_RR_EN defined: round-robin.
  - When both ports request, grant the port not served last.
  - The history bit updates at every grant.
  - After reset, the core wins the first tie.
- ARB_RR_EN undefined: fixed priority, debug wins every tie.
  - The history bit is not implemented.
  - The core can be starved by continuous debug traffic; this is intended for halt/load use.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_t` enum {IDLE, ACCESS, WAIT, RESP}
  - `arb_owner_t` {OWN_CORE, OWN_DBG}
  - constant `MEM_LAT_MAX`=7
- One sub-module, `arb_pick`: combinational two-way picker.
  - Inputs: the two requests and the history bit.
  - Output: the owner.
  - Contains the ARB_RR_EN-dependent logic.
- The FSM, counter and latches stay in `dmem_arbiter`.

## Test plan
- MEM_LAT=1, `core_req` load at addr 0x10, memory returns 0xDEADBEEF → `mem_en` in cycle 1, `core_ack` in cycle 3 with `core_rdata`=0xDEADBEEF, `core_stall` high in cycles 0–2.
- Core store addr 0x20 data 0x12345678 → exactly one cycle with `mem_en`=`mem_we`=1, `mem_addr`=0x20, `mem_wdata`=0x12345678. A follow-up load of 0x20 returns 0x12345678.
- Both ports request continuously, ARB_RR_EN defined → grants alternate core, dbg, core, dbg. Undefined → dbg is granted every time and `core_ack` never fires.
- MEM_LAT=4, dbg load → `dbg_ack` exactly at cycle 6; `grant_dbg` high cycles 1–6.
- `n_rst` low in the WAIT cycle of a core load → no `core_ack`, all outputs 0 next cycle. With `core_req` still high after reset release, a fresh transfer completes MEM_LAT+2 cycles later.
- Core changes `core_addr` from 0x10 to 0x30 during WAIT → the memory access and returned data still correspond to 0x10.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;

  typedef enum logic {OWN_CORE = 1'b0, OWN_DBG = 1'b1} arb_owner_t;

  localparam int unsigned MEM_LAT_MAX = 7;
  localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// arb_pick: combinational two-way owner picker for dmem_arbiter.
// ARB_RR_EN defined: round-robin on ties; undefined: debug wins every tie.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       core_req,
  input  logic       dbg_req,
  input  logic       last_dbg,
  output arb_owner_t owner
);

`ifdef ARB_RR_EN
  always_comb begin
    owner = OWN_CORE;
    if (core_req && dbg_req) begin
      owner = last_dbg ? OWN_CORE : OWN_DBG;
    end else if (dbg_req) begin
      owner = OWN_DBG;
    end
  end
`else
  // Fixed priority has no history; the port is kept so both builds share one top.
  logic unused_last_dbg;
  assign unused_last_dbg = last_dbg;

  always_comb begin
    owner = dbg_req ? OWN_DBG : OWN_CORE;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between core and debug ports.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of debug priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              grant_dbg
);

  arb_state_t       state, state_nxt;
  arb_owner_t       owner_q, pick;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             last_dbg;
  logic             any_req;
  logic             grant;

  assign any_req = core_req | dbg_req;
  assign grant   = (state == IDLE) && any_req;

  arb_pick u_pick (
    .core_req (core_req),
    .dbg_req  (dbg_req),
    .last_dbg (last_dbg),
    .owner    (pick)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      owner_q    <= OWN_CORE;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cnt        <= '0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner_q <= pick;
            if (pick == OWN_DBG) begin
              lat_we    <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
            end else begin
              lat_we    <= core_we;
              mem_addr  <= core_addr;
              mem_wdata <= core_wdata;
            end
          end
        end
        ACCESS: cnt <= CNT_W'(MEM_LAT - 1);
        WAIT: begin
          // Read data is captured on stores too; the value is simply unused.
          if (cnt == '0) begin
            if (owner_q == OWN_DBG) begin
              dbg_rdata <= mem_rdata;
            end else begin
              core_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_RR_EN
  // Reset value "debug last served" lets the core win the first tie.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      last_dbg <= 1'b1;
    end else if (grant) begin
      last_dbg <= (pick == OWN_DBG);
    end
  end
`else
  assign last_dbg = 1'b1;
`endif

  assign mem_en     = (state == ACCESS);
  assign mem_we     = mem_en & lat_we;
  assign core_ack   = (state == RESP) && (owner_q == OWN_CORE);
  assign dbg_ack    = (state == RESP) && (owner_q == OWN_DBG);
  assign grant_dbg  = (state != IDLE) && (owner_q == OWN_DBG);
  assign core_stall = core_req & ~core_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// transfers checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned LAT = 4;
  localparam int unsigned AW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic          core_req, core_we, core_ack, core_stall;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata, core_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, grant_dbg;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic          c1_req, c1_ack, c1_stall, d1_ack, m1_en, m1_we, g1_dbg;
  logic [31:0]   c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW)) u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ack   (core_ack),
    .core_stall (core_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .dbg_ack    (dbg_ack),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .grant_dbg  (grant_dbg)
  );

  dmem_arbiter #(.MEM_LAT(1), .ADDR_W(AW)) u_lat1 (
    .clk        (clk),
    .n_rst      (n_rst),
    .core_req   (c1_req),
    .core_we    (1'b0),
    .core_addr  (32'h10),
    .core_wdata (32'h0),
    .core_rdata (c1_rdata),
    .core_ack   (c1_ack),
    .core_stall (c1_stall),
    .dbg_req    (1'b0),
    .dbg_we     (1'b0),
    .dbg_addr   (32'h0),
    .dbg_wdata  (32'h0),
    .dbg_rdata  (d1_rdata),
    .dbg_ack    (d1_ack),
    .mem_en     (m1_en),
    .mem_we     (m1_we),
    .mem_addr   (m1_addr),
    .mem_wdata  (m1_wdata),
    .mem_rdata  (m1_rdata),
    .grant_dbg  (g1_dbg)
  );

  // Unwritten memory words read back as a pattern derived from the address.
  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: read data is valid only in the cycle LAT after mem_en.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_data   = '0;
  int          valid_cyc = -1;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      rd_data   <= mem.exists(mem_addr) ? mem[mem_addr] : fill(mem_addr);
      valid_cyc <= cyc + int'(LAT);
    end
  end
  assign mem_rdata = (cyc == valid_cyc) ? rd_data : ~rd_data;

  int en1_cyc = -100;
  always @(posedge clk) if (m1_en) en1_cyc <= cyc;
  assign m1_rdata = (cyc == en1_cyc + 1) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;

  typedef struct {
    int          c;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;
  acc_t acc_q[$];
  int   we_without_en = 0;
  always @(negedge clk) begin
    if (mem_en) acc_q.push_back('{cyc, mem_we, mem_addr, mem_wdata});
    if (mem_we && !mem_en) we_without_en++;
  end

  // Reference model: memory contents in service order and the last served port.
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_last_dbg = 1'b1;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present requests in one IDLE cycle and follow every transfer to its ack.
  task automatic run_pair(input bit c_on, input bit d_on,
                          input bit c_we, input logic [31:0] c_a, input logic [31:0] c_d,
                          input bit d_we, input logic [31:0] d_a, input logic [31:0] d_d);
    int t0, c_at, d_at, last;
    bit dbg_first, c_pend, exp_c, exp_d, exp_g, exp_s;
    acc_t a;
    t0 = cyc;
    core_req = c_on; core_we = c_we; core_addr = c_a; core_wdata = c_d;
    dbg_req  = d_on; dbg_we  = d_we; dbg_addr  = d_a; dbg_wdata  = d_d;
`ifdef ARB_RR_EN
    dbg_first = d_on && !(c_on && ref_last_dbg);
`else
    dbg_first = d_on;
`endif
    c_at = -1; d_at = -1;
    if (dbg_first) begin
      d_at = t0 + int'(LAT) + 2;
      if (c_on) c_at = d_at + int'(LAT) + 3;
    end else begin
      if (c_on) c_at = t0 + int'(LAT) + 2;
      if (d_on) d_at = c_at + int'(LAT) + 3;
    end
    last = (c_at > d_at) ? c_at : d_at;
    c_pend = c_on;
    for (int k = 0; k <= last - t0; k++) begin
      @(negedge clk);
      exp_c = (cyc == c_at);
      exp_d = (cyc == d_at);
      exp_g = d_on && (cyc >= d_at - int'(LAT) - 1) && (cyc <= d_at);
      exp_s = c_pend && !exp_c;
      checks++;
      if (core_ack !== exp_c) begin
        failures++; $display("FAIL xfer_core_ack cyc=%0d got=%b expected=%b", cyc - t0, core_ack, exp_c);
      end
      checks++;
      if (dbg_ack !== exp_d) begin
        failures++; $display("FAIL xfer_dbg_ack cyc=%0d got=%b expected=%b", cyc - t0, dbg_ack, exp_d);
      end
      checks++;
      if (grant_dbg !== exp_g) begin
        failures++; $display("FAIL xfer_grant_dbg cyc=%0d got=%b expected=%b", cyc - t0, grant_dbg, exp_g);
      end
      checks++;
      if (core_stall !== exp_s) begin
        failures++; $display("FAIL xfer_core_stall cyc=%0d got=%b expected=%b", cyc - t0, core_stall, exp_s);
      end
      if (exp_c) begin
        if (!c_we) begin
          checks++;
          if (core_rdata !== ref_read(c_a)) begin
            failures++; $display("FAIL xfer_core_rdata addr=%h got=%h expected=%h", c_a, core_rdata, ref_read(c_a));
          end
        end
        checks++;
        if (acc_q.size() == 0) begin
          failures++; $display("FAIL xfer_core_access got=none expected=addr %h", c_a);
        end else begin
          a = acc_q[acc_q.size()-1];
          if (a.c != cyc - int'(LAT) - 1 || a.we !== c_we || a.addr !== c_a || (c_we && a.wdata !== c_d)) begin
            failures++;
            $display("FAIL xfer_core_access got=cyc%0d we%b %h %h expected=cyc%0d we%b %h %h",
                     a.c - t0, a.we, a.addr, a.wdata, cyc - int'(LAT) - 1 - t0, c_we, c_a, c_d);
          end
        end
        if (c_we) ref_mem[c_a] = c_d;
        ref_last_dbg = 1'b0; c_pend = 1'b0; core_req = 1'b0;
      end
      if (exp_d) begin
        if (!d_we) begin
          checks++;
          if (dbg_rdata !== ref_read(d_a)) begin
            failures++; $display("FAIL xfer_dbg_rdata addr=%h got=%h expected=%h", d_a, dbg_rdata, ref_read(d_a));
          end
        end
        checks++;
        if (acc_q.size() == 0) begin
          failures++; $display("FAIL xfer_dbg_access got=none expected=addr %h", d_a);
        end else begin
          a = acc_q[acc_q.size()-1];
          if (a.c != cyc - int'(LAT) - 1 || a.we !== d_we || a.addr !== d_a || (d_we && a.wdata !== d_d)) begin
            failures++;
            $display("FAIL xfer_dbg_access got=cyc%0d we%b %h %h expected=cyc%0d we%b %h %h",
                     a.c - t0, a.we, a.addr, a.wdata, cyc - int'(LAT) - 1 - t0, d_we, d_a, d_d);
          end
        end
        if (d_we) ref_mem[d_a] = d_d;
        ref_last_dbg = 1'b1; dbg_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
    c1_req = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1) begin
      failures++; $display("FAIL reset_stall got=%b expected=1", core_stall);
    end
    core_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, core_rdata, dbg_rdata, core_ack, dbg_ack, grant_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0",
               {mem_en, mem_we, mem_addr, mem_wdata, core_rdata, dbg_rdata, core_ack, dbg_ack, grant_dbg});
    end
    checks++;
    if ({m1_en, m1_we, m1_addr, m1_wdata, c1_rdata, d1_rdata, c1_ack, d1_ack, g1_dbg} !== '0) begin
      failures++; $display("FAIL reset_outputs_lat1 got=%h expected=0",
                           {m1_en, m1_we, m1_addr, m1_wdata, c1_rdata, d1_rdata, c1_ack, d1_ack, g1_dbg});
    end
    tick();
    n_rst = 1'b1;
    ref_last_dbg = 1'b1;
    tick();
  endtask

  task automatic test_min_latency();
    bit exp_en, exp_ack, exp_st;
    c1_req = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      exp_en  = (k == 1);
      exp_ack = (k == 3);
      exp_st  = (k < 3);
      checks++;
      if (m1_en !== exp_en) begin
        failures++; $display("FAIL lat1_mem_en cyc=%0d got=%b expected=%b", k, m1_en, exp_en);
      end
      checks++;
      if (c1_ack !== exp_ack) begin
        failures++; $display("FAIL lat1_core_ack cyc=%0d got=%b expected=%b", k, c1_ack, exp_ack);
      end
      checks++;
      if (c1_stall !== exp_st) begin
        failures++; $display("FAIL lat1_core_stall cyc=%0d got=%b expected=%b", k, c1_stall, exp_st);
      end
      if (exp_ack) begin
        checks++;
        if (c1_rdata !== 32'hDEAD_BEEF) begin
          failures++; $display("FAIL lat1_rdata got=%h expected=deadbeef", c1_rdata);
        end
        c1_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_store_load();
    int n0;
    n0 = acc_q.size();
    run_pair(1'b1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, '0, '0);
    checks++;
    if (acc_q.size() != n0 + 1) begin
      failures++; $display("FAIL store_strobe_count got=%0d expected=1", acc_q.size() - n0);
    end else begin
      checks++;
      if (acc_q[n0].we !== 1'b1 || acc_q[n0].addr !== 32'h20 || acc_q[n0].wdata !== 32'h1234_5678) begin
        failures++; $display("FAIL store_fields got=we%b %h %h expected=we1 00000020 12345678",
                             acc_q[n0].we, acc_q[n0].addr, acc_q[n0].wdata);
      end
    end
    run_pair(1'b1, 1'b0, 1'b0, 32'h20, '0, 1'b0, '0, '0);
    checks++;
    if (core_rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL load_back got=%h expected=12345678", core_rdata);
    end
  endtask

  task automatic test_dbg_latency();
    run_pair(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 32'h44, '0);
  endtask

  task automatic test_arbitration();
    int  t0, n;
    bit  exp_dbg [6];
    int  ack_at [6];
    bit  last, exp_c, exp_d;
    t0 = cyc;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h80;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h84;
    last = ref_last_dbg;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
      exp_dbg[i] = !last;
`else
      exp_dbg[i] = 1'b1;
`endif
      last = exp_dbg[i];
      ack_at[i] = t0 + int'(LAT) + 2 + i * (int'(LAT) + 3);
    end
    n = 0;
    for (int k = 0; k <= ack_at[5] - t0; k++) begin
      @(negedge clk);
      exp_c = (n < 6) && (cyc == ack_at[n]) && !exp_dbg[n];
      exp_d = (n < 6) && (cyc == ack_at[n]) && exp_dbg[n];
      checks++;
      if (core_ack !== exp_c) begin
        failures++; $display("FAIL arb_core_ack cyc=%0d got=%b expected=%b", cyc - t0, core_ack, exp_c);
      end
      checks++;
      if (dbg_ack !== exp_d) begin
        failures++; $display("FAIL arb_dbg_ack cyc=%0d got=%b expected=%b", cyc - t0, dbg_ack, exp_d);
      end
      if (exp_c) begin
        checks++;
        if (core_rdata !== ref_read(32'h80)) begin
          failures++; $display("FAIL arb_core_rdata got=%h expected=%h", core_rdata, ref_read(32'h80));
        end
      end
      if (exp_d) begin
        checks++;
        if (dbg_rdata !== ref_read(32'h84)) begin
          failures++; $display("FAIL arb_dbg_rdata got=%h expected=%h", dbg_rdata, ref_read(32'h84));
        end
      end
      if (exp_c || exp_d) begin
        ref_last_dbg = exp_dbg[n];
        n++;
        if (n == 6) begin
          core_req = 1'b0; dbg_req = 1'b0;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_transfer();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; dbg_req = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (core_ack !== 1'b0) begin
        failures++; $display("FAIL rstmid_no_ack cyc=%0d got=%b expected=0", k, core_ack);
      end
      if (k == 3) n_rst = 1'b0;
      tick();
    end
    n_rst = 1'b1;
    ref_last_dbg = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, core_rdata, dbg_rdata, core_ack, dbg_ack, grant_dbg} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h expected=0",
               {mem_en, mem_we, mem_addr, mem_wdata, core_rdata, dbg_rdata, core_ack, dbg_ack, grant_dbg});
    end
    // core_req is still high: this IDLE cycle starts a fresh transfer.
    @(posedge clk);
    #1;
    run_pair_from_prev();
  endtask

  // The fresh post-reset transfer was sampled in the previous (IDLE) cycle.
  task automatic run_pair_from_prev();
    int t_rel, ack_at;
    bit exp_c;
    t_rel  = cyc - 1;
    ack_at = t_rel + int'(LAT) + 2;
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      @(negedge clk);
      exp_c = (cyc == ack_at);
      checks++;
      if (core_ack !== exp_c) begin
        failures++; $display("FAIL rstmid_fresh_ack cyc=%0d got=%b expected=%b", cyc - t_rel, core_ack, exp_c);
      end
      if (exp_c) begin
        checks++;
        if (core_rdata !== ref_read(32'h10)) begin
          failures++; $display("FAIL rstmid_fresh_rdata got=%h expected=%h", core_rdata, ref_read(32'h10));
        end
        core_req = 1'b0;
        ref_last_dbg = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_addr_hold();
    bit exp_c;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; dbg_req = 1'b0;
    for (int k = 0; k <= int'(LAT) + 2; k++) begin
      @(negedge clk);
      exp_c = (k == int'(LAT) + 2);
      checks++;
      if (core_ack !== exp_c) begin
        failures++; $display("FAIL addr_hold_ack cyc=%0d got=%b expected=%b", k, core_ack, exp_c);
      end
      if (exp_c) begin
        checks++;
        if (core_rdata !== ref_read(32'h10)) begin
          failures++; $display("FAIL addr_hold_rdata got=%h expected=%h", core_rdata, ref_read(32'h10));
        end
        checks++;
        if (acc_q.size() == 0 || acc_q[acc_q.size()-1].addr !== 32'h10) begin
          failures++; $display("FAIL addr_hold_mem_addr got=%h expected=00000010",
                               (acc_q.size() == 0) ? 32'hx : acc_q[acc_q.size()-1].addr);
        end
        core_req = 1'b0;
        ref_last_dbg = 1'b0;
      end
      if (k == 3) core_addr = 32'h30;
      tick();
    end
    core_addr = 32'h10;
  endtask

  task automatic test_random();
    int unsigned pat;
    bit c_on, d_on;
    for (int i = 0; i < 16; i++) begin
      pat  = $urandom_range(0, 2);
      c_on = (pat != 1);
      d_on = (pat != 0);
      run_pair(c_on, d_on,
               1'($urandom_range(0, 1)), 32'h100 + 4 * $urandom_range(0, 7), $urandom,
               1'($urandom_range(0, 1)), 32'h100 + 4 * $urandom_range(0, 7), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (we_without_en != 0) begin
      failures++; $display("FAIL mem_we_without_en got=%0d expected=0", we_without_en);
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_store_load();
    test_dbg_latency();
    test_arbitration();
    test_reset_mid_transfer();
    test_addr_hold();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
